// File: rtl/ring_seq_fsm.sv
// Ring step sequencer over N_STATES states with direction control, synchronous load,
// per-state dwell timeout abort and registered wrap/timeout/load-error pulses.
module ring_seq_fsm #(
  parameter int unsigned N_STATES = 7,
  parameter int unsigned SW       = 4,
  parameter int unsigned TO_W     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [N_STATES-1:0] adv,
  input  logic                rev,
  input  logic                load,
  input  logic [SW-1:0]       load_val,
  input  logic [TO_W-1:0]     timeout,
  output logic [SW-1:0]       y,
  output logic [TO_W-1:0]     dwell,
  output logic                wrap,
  output logic                to_evt,
  output logic                load_err
);

  localparam logic [SW:0]   NumStates = (SW+1)'(N_STATES);
  localparam logic [SW-1:0] LastState = SW'(N_STATES - 1);

  logic adv_cur;
  logic load_ok;
  logic to_hit;

  // Select adv[y] without a width-mismatched index into the request vector.
  always_comb begin
    adv_cur = 1'b0;
    for (int k = 0; k < N_STATES; k++) begin
      if (y == SW'(k)) adv_cur = adv[k];
    end
  end

  assign load_ok = ({1'b0, load_val} < NumStates);
  // Exact match only: lowering timeout below the current dwell never aborts.
  assign to_hit  = (timeout != '0) && (dwell == timeout - TO_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      y        <= '0;
      dwell    <= '0;
      wrap     <= 1'b0;
      to_evt   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      to_evt   <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          y     <= load_val;
          dwell <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en && adv_cur) begin
        dwell <= '0;
        if (!rev) begin
          if (y == LastState) begin
            y    <= '0;
            wrap <= 1'b1;
          end else begin
            y <= y + SW'(1);
          end
        end else begin
          if (y == '0) begin
            y    <= LastState;
            wrap <= 1'b1;
          end else begin
            y <= y - SW'(1);
          end
        end
      end else if (en && to_hit) begin
        y      <= '0;
        dwell  <= '0;
        to_evt <= 1'b1;
      end else if (en && (dwell != '1)) begin
        dwell <= dwell + TO_W'(1);
      end
    end
  end

endmodule

// File: doc/ring_seq_fsm.md
Name: ring_seq_fsm

Overview:
- Parametrised ring sequencer that steps through N_STATES states, numbered 0..N_STATES-1. It leaves state k when its per-state advance input adv[k] is high.
- It extends the fixed 7-state ring controller with:
  - runtime direction control (forward/reverse),
  - a synchronous state load,
  - a per-state dwell timeout that aborts back to state 0,
  - registered wrap, timeout and load-error event pulses.
- It sits in control paths as a step sequencer feeding mux selects and enables downstream.

Parameters:
- N_STATES, 7: number of ring states; legal range 2..2^SW.
- SW, 4: state/output width; must satisfy 2^SW >= N_STATES.
- TO_W, 8: width of the dwell counter and of the timeout input.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global step/count enable.
- adv  in  N_STATES  per-state advance request; only adv[state] is examined.
- rev  in  1  direction: 0 = forward (k→k+1), 1 = reverse (k→k-1).
- load  in  1  synchronous state load request.
- load_val  in  SW  state to load.
- timeout  in  TO_W  maximum dwell in cycles; 0 disables the timeout.
- y  out  SW  current state (registered).
- dwell  out  TO_W  enabled cycles spent in the current state (registered).
- wrap  out  1  one-cycle pulse on a ring wrap.
- to_evt  out  1  one-cycle pulse on a timeout abort.
- load_err  out  1  one-cycle pulse on an out-of-range load.

Behaviour:
- Reset (reset=1 at a rising edge): y=0, dwell=0, wrap=0, to_evt=0, load_err=0. Reset has priority over every other input.
- All outputs are registered. A decision made on inputs in cycle n appears on y and the pulses in cycle n+1. The pulses are asserted together with the new y value.
- Next-state priority, highest first:
  1. load
  2. advance
  3. timeout
  4. hold
- Load:
  - Condition: load=1, independent of en.
  - If load_val < N_STATES: y←load_val, dwell←0.
  - Otherwise: y and dwell are unchanged and load_err pulses.
  - A load suppresses advance and timeout in the same cycle, even when the load is rejected.
- Advance:
  - Condition: en=1 and adv[y]=1, with no load.
  - Forward: y←y+1; from N_STATES-1 the next state is 0 and wrap pulses.
  - Reverse: y←y-1; from 0 the next state is N_STATES-1 and wrap pulses.
  - Wrap-around uses explicit compare against N_STATES, not power-of-two overflow.
  - dwell←0 on every advance, including self-loop cases.
- Timeout:
  - Condition: en=1, timeout≠0, no load, no advance, and dwell==timeout-1.
  - Action: y←0, dwell←0, to_evt pulses, wrap stays 0.
  - A timeout while already in state 0 still pulses to_evt and clears dwell.
- Hold:
  - With no load, advance or timeout, y is unchanged.
  - dwell increments when en=1 and saturates at 2^TO_W-1; it is frozen when en=0.
  - With timeout=0, dwell saturates and no abort occurs.
- en=0 blocks advance and timeout; it does not block load.
- Changing timeout while in a state takes effect immediately against the current dwell.
  - If dwell is already ≥ timeout, no abort fires, because an exact match is required.
  - dwell then continues to saturation.
- rev and adv are sampled only in the cycle of the step; a direction change between steps is allowed.
- Reset asserted mid-dwell or mid-pulse clears all outputs on the next edge; no pulse is extended.

Test Plan:
- Reset, then en=1 and adv=all-ones, rev=0, for 8 cycles → y=1,2,3,4,5,6,0,1; wrap=1 only in the cycle y becomes 0.
- Hold at y=0, set rev=1 and adv[0]=1 for 1 cycle → y=6, wrap=1. Then adv[6]=1 → y=5, wrap=0.
- timeout=4, en=1, adv=0 starting from y=3 → dwell=0,1,2,3; next cycle y=0, to_evt=1, dwell=0. Repeat with en toggling 1/0 → abort occurs after 4 enabled cycles only.
- load=1 with load_val=5 while adv[y]=1 and en=0 → y=5, dwell=0, no wrap. Then load_val=9 (N_STATES=7) → y stays 5, load_err=1 for one cycle.
- Assert reset while dwell=3 and adv[y]=1 → next cycle y=0, dwell=0, all pulses 0. Also cover timeout=0 with adv=0 for 300 cycles (TO_W=8) → dwell saturates at 255, y unchanged, to_evt never asserted.
- Re-parametrise N_STATES=3, SW=2: forward stepping gives y=0,1,2,0; loading load_val=3 → load_err=1 and y unchanged.
